// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 access sizes, write-back source
// select and the bus FSM state type.
package mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   function automatic logic f3_legal(input logic [2:0] f3, input logic store);
      if (store)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data-path of the MEM stage: store lane replication and byte
// enables, load byte/half extraction with extension, and fault detection.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_ext,
   output logic        fault
);

   logic        misalign;
   logic [31:0] rdata_shift;

   always_comb begin
      misalign = 1'b0;
      if (funct3[1:0] == 2'b01)
         misalign = addr_lo[0];
      else if (funct3[1:0] == 2'b10)
         misalign = (addr_lo != 2'b00);
      fault = (is_load | is_store) & (~f3_legal(funct3, is_store) | misalign);
   end

   always_comb begin
      be = 4'b0000;
      if (is_store) begin
         case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
         endcase
      end else if (is_load) begin
         be = 4'b1111;
      end
   end

   // Each lane carries the byte the memory would pick for that lane.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata[8*gi +: 8] = (funct3 == F3_B) ? store_data[7:0] :
                                (funct3 == F3_H) ? store_data[8*(gi%2) +: 8] :
                                                   store_data[8*gi +: 8];
   end

   assign rdata_shift = rdata >> {addr_lo, 3'b000};

   always_comb begin
      case (funct3)
         F3_B:    load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
         F3_H:    load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
         F3_BU:   load_ext = {24'd0, rdata_shift[7:0]};
         F3_HU:   load_ext = {16'd0, rdata_shift[15:0]};
         default: load_ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: data-memory bus handshake with timeout,
// upstream stall generation and the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALU_out_EXMEM,
   input  logic [2:0]  funct3_EXMEM,
   input  logic        mem_wr_en_EXMEM,
   input  logic [31:0] rs2_data_EXMEM,
   input  logic        reg_wr_en_EXMEM,
   input  logic [1:0]  reg_wr_ctrl_EXMEM,
   input  logic [4:0]  rd_EXMEM,
   input  logic [31:0] pc_4_EXMEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        stall_MEM,
   output logic        misalign_MEM,
   output logic        bus_err_MEM,
   output logic [31:0] ALU_out_MEMWB,
   output logic [31:0] load_data_MEMWB,
   output logic        reg_wr_en_MEMWB,
   output logic [1:0]  reg_wr_ctrl_MEMWB,
   output logic [4:0]  rd_MEMWB,
   output logic [31:0] pc_4_MEMWB
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic        is_load;
   logic        is_store;
   logic        fault;
   logic        legal_access;
   logic        abort;
   logic        stall_int;
   logic [31:0] load_ext;

   mem_state_e  state_reg;
   logic [7:0]  cnt_reg;

   logic [31:0] alu_out_reg;
   logic [31:0] load_data_reg;
   logic        reg_wr_en_reg;
   logic [1:0]  reg_wr_ctrl_reg;
   logic [4:0]  rd_reg;
   logic [31:0] pc_4_reg;

   assign is_load  = reg_wr_en_EXMEM & (reg_wr_ctrl_EXMEM == WB_MEM);
   assign is_store = mem_wr_en_EXMEM;

   mem_align u_align (
      .addr_lo    (ALU_out_EXMEM[1:0]),
      .funct3     (funct3_EXMEM),
      .is_load    (is_load),
      .is_store   (is_store),
      .store_data (rs2_data_EXMEM),
      .rdata      (dmem_rdata),
      .be         (dmem_be),
      .wdata      (dmem_wdata),
      .load_ext   (load_ext),
      .fault      (fault)
   );

   assign legal_access = (is_load | is_store) & ~fault;
   // A late ready on the final allowed cycle wins over the timeout.
   assign abort     = legal_access & (state_reg == ST_WAIT) & ~dmem_ready &
                      (cnt_reg == TIMEOUT_CNT);
   assign stall_int = legal_access & ~(dmem_ready | abort);

   assign dmem_req     = legal_access & reset;
   assign dmem_we      = is_store;
   assign dmem_addr    = {ALU_out_EXMEM[31:2], 2'b00};
   assign stall_MEM    = stall_int & reset;
   assign misalign_MEM = (is_load | is_store) & fault & reset;
   assign bus_err_MEM  = abort & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 8'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (legal_access && !dmem_ready) begin
                  state_reg <= ST_WAIT;
                  cnt_reg   <= 8'd1;
               end
            end
            ST_WAIT: begin
               if (!legal_access || dmem_ready || abort) begin
                  state_reg <= ST_IDLE;
                  cnt_reg   <= 8'd0;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               cnt_reg   <= 8'd0;
            end
         endcase
      end
   end

   // Stalls, faults and aborts all push a bubble; payload fields simply hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_out_reg     <= 32'd0;
         load_data_reg   <= 32'd0;
         reg_wr_en_reg   <= 1'b0;
         reg_wr_ctrl_reg <= 2'b00;
         rd_reg          <= 5'd0;
         pc_4_reg        <= 32'd0;
      end else if (stall_int || fault || abort) begin
         reg_wr_en_reg <= 1'b0;
      end else begin
         alu_out_reg     <= ALU_out_EXMEM;
         load_data_reg   <= load_ext;
         reg_wr_en_reg   <= reg_wr_en_EXMEM;
         reg_wr_ctrl_reg <= reg_wr_ctrl_EXMEM;
         rd_reg          <= rd_EXMEM;
         pc_4_reg        <= pc_4_EXMEM;
      end
   end

   assign ALU_out_MEMWB     = alu_out_reg;
   assign load_data_MEMWB   = load_data_reg;
   assign reg_wr_en_MEMWB   = reg_wr_en_reg;
   assign reg_wr_ctrl_MEMWB = reg_wr_ctrl_reg;
   assign rd_MEMWB          = rd_reg;
   assign pc_4_MEMWB        = pc_4_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of the
// access rules, lane formatting, load extension and timeout behaviour.
module tb_mem_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ALU_out_EXMEM = '0;
   logic [2:0]  funct3_EXMEM = '0;
   logic        mem_wr_en_EXMEM = 1'b0;
   logic [31:0] rs2_data_EXMEM = '0;
   logic        reg_wr_en_EXMEM = 1'b0;
   logic [1:0]  reg_wr_ctrl_EXMEM = '0;
   logic [4:0]  rd_EXMEM = '0;
   logic [31:0] pc_4_EXMEM = '0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        stall_MEM;
   logic        misalign_MEM;
   logic        bus_err_MEM;
   logic [31:0] ALU_out_MEMWB;
   logic [31:0] load_data_MEMWB;
   logic        reg_wr_en_MEMWB;
   logic [1:0]  reg_wr_ctrl_MEMWB;
   logic [4:0]  rd_MEMWB;
   logic [31:0] pc_4_MEMWB;

   int n_vec = 0;
   int n_bad = 0;
   int n_txn = 0;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk               (clk),
      .reset             (reset),
      .ALU_out_EXMEM     (ALU_out_EXMEM),
      .funct3_EXMEM      (funct3_EXMEM),
      .mem_wr_en_EXMEM   (mem_wr_en_EXMEM),
      .rs2_data_EXMEM    (rs2_data_EXMEM),
      .reg_wr_en_EXMEM   (reg_wr_en_EXMEM),
      .reg_wr_ctrl_EXMEM (reg_wr_ctrl_EXMEM),
      .rd_EXMEM          (rd_EXMEM),
      .pc_4_EXMEM        (pc_4_EXMEM),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_be           (dmem_be),
      .dmem_wdata        (dmem_wdata),
      .dmem_ready        (dmem_ready),
      .dmem_rdata        (dmem_rdata),
      .stall_MEM         (stall_MEM),
      .misalign_MEM      (misalign_MEM),
      .bus_err_MEM       (bus_err_MEM),
      .ALU_out_MEMWB     (ALU_out_MEMWB),
      .load_data_MEMWB   (load_data_MEMWB),
      .reg_wr_en_MEMWB   (reg_wr_en_MEMWB),
      .reg_wr_ctrl_MEMWB (reg_wr_ctrl_MEMWB),
      .rd_MEMWB          (rd_MEMWB),
      .pc_4_MEMWB        (pc_4_MEMWB)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
      end
   endtask

   // One instruction held in EX/MEM until the stage lets it go; delay is the
   // cycle (counted from 0) on which the memory answers.
   task automatic run_instr(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rs2, input logic [31:0] rdata,
                            input logic st, input logic wen, input logic [1:0] ctrl,
                            input logic [4:0] rd, input logic [31:0] pc4, input int delay);
      bit ld, acc, ok, done, abrt, stl, f3ok;
      int nb;
      logic [3:0]  be_e;
      logic [31:0] wd_e, ld_e, w;
      ld   = wen && (ctrl == 2'b01);
      acc  = ld || st;
      f3ok = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      nb   = 1 << f3[1:0];
      ok   = acc && f3ok && ((int'(a[1:0]) % nb) == 0);
      if (!st)          be_e = 4'hF;
      else if (f3 == 0) be_e = 4'(1 << a[1:0]);
      else if (f3 == 1) be_e = 4'(3 << (2 * int'(a[1])));
      else              be_e = 4'hF;
      if (f3 == 0)      wd_e = rs2[7:0] * 32'h0101_0101;
      else if (f3 == 1) wd_e = rs2[15:0] * 32'h0001_0001;
      else              wd_e = rs2;
      w = rdata >> (8 * int'(a[1:0]));
      case (f3)
         3'd0:    ld_e = 32'($signed(w[7:0]));
         3'd1:    ld_e = 32'($signed(w[15:0]));
         3'd4:    ld_e = {24'd0, w[7:0]};
         3'd5:    ld_e = {16'd0, w[15:0]};
         default: ld_e = rdata;
      endcase
      done = 0;
      abrt = 0;
      for (int k = 0; k <= TO + 1 && !done; k++) begin
         @(negedge clk);
         ALU_out_EXMEM     = a;
         funct3_EXMEM      = f3;
         mem_wr_en_EXMEM   = st;
         rs2_data_EXMEM    = rs2;
         reg_wr_en_EXMEM   = wen;
         reg_wr_ctrl_EXMEM = ctrl;
         rd_EXMEM          = rd;
         pc_4_EXMEM        = pc4;
         dmem_ready        = (k == delay);
         dmem_rdata        = (k == delay) ? rdata : $urandom;
         #1;
         abrt = ok && (k == TO) && (k != delay);
         stl  = ok && (k != delay) && !abrt;
         check("dmem_req", dmem_req, ok);
         if (ok) begin
            check("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
            check("dmem_we", dmem_we, st);
            check("dmem_be", dmem_be, be_e);
            if (st) check("dmem_wdata", dmem_wdata, wd_e);
         end
         check("stall_MEM", stall_MEM, stl);
         check("misalign_MEM", misalign_MEM, acc && !ok);
         check("bus_err_MEM", bus_err_MEM, abrt);
         @(posedge clk);
         #1;
         if (stl) begin
            check("wb_bubble_stall", reg_wr_en_MEMWB, 0);
         end else begin
            done = 1;
            if ((acc && !ok) || abrt) begin
               check("wb_bubble", reg_wr_en_MEMWB, 0);
            end else begin
               check("wb_wr_en", reg_wr_en_MEMWB, wen);
               check("wb_ctrl", reg_wr_ctrl_MEMWB, ctrl);
               check("wb_rd", rd_MEMWB, rd);
               check("wb_alu", ALU_out_MEMWB, a);
               check("wb_pc4", pc_4_MEMWB, pc4);
               if (ld) check("wb_load", load_data_MEMWB, ld_e);
            end
         end
      end
      check("txn_done", done, 1);
      n_txn++;
      $display("txn %0d: f3=%0d a=%08h st=%0d ld=%0d delay=%0d legal=%0d abort=%0d",
               n_txn, f3, a, st, ld, delay, ok, abrt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [1:0]  ctrl;
      logic        wen, st;
      int          kind;

      repeat (2) @(posedge clk);
      #1;
      check("rst_req", dmem_req, 0);
      check("rst_wb_en", reg_wr_en_MEMWB, 0);
      check("rst_wb_alu", ALU_out_MEMWB, 0);
      check("rst_misalign", misalign_MEM, 0);
      check("rst_bus_err", bus_err_MEM, 0);
      @(negedge clk);
      reset = 1'b1;

      // SB, zero wait states
      run_instr(3'd0, 32'h1002, 32'h0000_00AB, 32'h0, 1'b1, 1'b0, 2'b00, 5'd0, 32'h100, 0);
      // LB / LBU with three wait states
      run_instr(3'd0, 32'h2003, 32'h0, 32'h80FF_7F01, 1'b0, 1'b1, 2'b01, 5'd7, 32'h104, 3);
      run_instr(3'd4, 32'h2003, 32'h0, 32'h80FF_7F01, 1'b0, 1'b1, 2'b01, 5'd8, 32'h108, 3);
      // misaligned LH and LW
      run_instr(3'd1, 32'h2001, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 2'b01, 5'd9, 32'h10C, 0);
      run_instr(3'd2, 32'h2006, 32'h0, 32'h1234_5678, 1'b0, 1'b1, 2'b01, 5'd9, 32'h110, 0);
      // LW timing out
      run_instr(3'd2, 32'h3000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b01, 5'd3, 32'h114, 99);
      // ready on the last allowed cycle is a completion
      run_instr(3'd2, 32'h3004, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b01, 5'd4, 32'h118, TO);
      // ADD pass-through
      run_instr(3'd0, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 5'd5, 32'h11C, 0);

      // reset in the middle of a waiting LW
      @(negedge clk);
      ALU_out_EXMEM     = 32'h4000;
      funct3_EXMEM      = 3'd2;
      mem_wr_en_EXMEM   = 1'b0;
      reg_wr_en_EXMEM   = 1'b1;
      reg_wr_ctrl_EXMEM = 2'b01;
      dmem_ready        = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("wait_req", dmem_req, 1);
      reset = 1'b0;
      #1;
      check("midrst_req", dmem_req, 0);
      check("midrst_wb_en", reg_wr_en_MEMWB, 0);
      check("midrst_wb_alu", ALU_out_MEMWB, 0);
      check("midrst_wb_load", load_data_MEMWB, 0);
      check("midrst_wb_rd", rd_MEMWB, 0);
      check("midrst_wb_ctrl", reg_wr_ctrl_MEMWB, 0);
      check("midrst_wb_pc4", pc_4_MEMWB, 0);
      check("midrst_bus_err", bus_err_MEM, 0);
      reg_wr_en_EXMEM   = 1'b0;
      reg_wr_ctrl_EXMEM = 2'b00;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_rst_req", dmem_req, 0);
      check("post_rst_stall", stall_MEM, 0);

      for (int i = 0; i < 250; i++) begin
         kind = $urandom_range(0, 3);
         a    = $urandom;
         f3   = 3'($urandom_range(0, 7));
         ctrl = 2'($urandom_range(0, 3));
         case (kind)
            0: begin
               st  = 1'b0;
               wen = 1'($urandom);
               if (wen && ctrl == 2'b01) ctrl = 2'b10;
            end
            3: begin
               st  = 1'b1;
               wen = 1'b0;
            end
            default: begin
               st   = 1'b0;
               wen  = 1'b1;
               ctrl = 2'b01;
            end
         endcase
         run_instr(f3, a, $urandom, $urandom, st, wen, ctrl, 5'($urandom), $urandom,
                   $urandom_range(0, TO + 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
